// File: rtl/sched_pkg.sv
// Shared encodings for the hardware round-robin process scheduler:
// FSM states, per-slot process states, switch cause codes and the OS PID.
package sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_SAVE   = 3'd2,
      ST_SELECT = 3'd3,
      ST_SWITCH = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_READY   = 2'd1,
      SLOT_BLOCKED = 2'd2,
      SLOT_RUNNING = 2'd3
   } slot_e;

   typedef enum logic [1:0] {
      CAUSE_QUANTUM = 2'b00,
      CAUSE_IO      = 2'b01,
      CAUSE_END     = 2'b10,
      CAUSE_INIT    = 2'b11
   } cause_e;

   localparam int unsigned OS_PID = 0;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first set bit of mask_i
// scanning upward from start_i and wrapping modulo NPROC.
module rr_pick #(
   parameter int NPROC = 8,
   parameter int PID_W = 3
) (
   input  logic [NPROC-1:0] mask_i,
   input  logic [PID_W-1:0] start_i,
   output logic             found_o,
   output logic [PID_W-1:0] pid_o
);

   localparam int SW = PID_W + 1;

   logic [SW-1:0] idx;

   always_comb begin
      found_o = 1'b0;
      pid_o   = '0;
      idx     = '0;
      for (int k = 0; k < NPROC; k++) begin
         idx = {1'b0, start_i} + SW'(k);
         if (idx >= SW'(NPROC)) begin
            idx = idx - SW'(NPROC);
         end
         if (!found_o && mask_i[idx[PID_W-1:0]]) begin
            found_o = 1'b1;
            pid_o   = idx[PID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/process_scheduler_rr.sv
// Hardware round-robin process scheduler: tracks slot states, counts the
// quantum in retired instructions, saves the preempted PC and dispatches the next PID.
module process_scheduler_rr
   import sched_pkg::*;
#(
   parameter int NPROC   = 8,
   parameter int PID_W   = $clog2(NPROC),
   parameter int QUANTUM = 16,
   parameter int PC_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             instr_retired,
   input  logic             proc_create,
   input  logic [PID_W-1:0] proc_create_pid,
   input  logic             io_request,
   input  logic             io_done,
   input  logic [PID_W-1:0] io_done_pid,
   input  logic             proc_end,
   input  logic [PC_W-1:0]  pc_current,
   input  logic             ctx_ack,
   output logic             switch_req,
   output logic [1:0]       switch_cause,
   output logic [PID_W-1:0] next_pid,
   output logic [PC_W-1:0]  restore_pc,
   output logic [PID_W-1:0] current_pid,
   output logic             idle,
   output logic [NPROC-1:0] ready_mask
);

   localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

   state_e           state_q, state_d;
   slot_e            slot_q  [NPROC];
   slot_e            slot_d  [NPROC];
   logic [PC_W-1:0]  pc_q    [NPROC];
   logic [PC_W-1:0]  pc_d    [NPROC];
   logic [QW-1:0]    quant_q, quant_d;
   logic [PID_W-1:0] cur_q, cur_d;
   logic [PID_W-1:0] nxt_q, nxt_d;
   logic [PC_W-1:0]  rpc_q, rpc_d;
   cause_e           cause_q, cause_d;

   logic [NPROC-1:0] ready_vec;
   logic [NPROC-1:0] run_vec;
   logic [PID_W-1:0] pick_start;
   logic             pick_found;
   logic [PID_W-1:0] pick_pid;

   logic run_active;
   logic expiry;
   logic ev_end;
   logic ev_io;
   logic ev_exp_sw;
   logic go_save;

   always_comb begin
      ready_vec = '0;
      run_vec   = '0;
      for (int i = 1; i < NPROC; i++) begin
         ready_vec[i] = (slot_q[i] == SLOT_READY);
         run_vec[i]   = (slot_q[i] == SLOT_RUNNING);
      end
   end

   // The scan begins just after the current PID so the preempted one is found last.
   assign pick_start = (cur_q == PID_W'(NPROC - 1)) ? '0 : cur_q + PID_W'(1);

   rr_pick #(
      .NPROC (NPROC),
      .PID_W (PID_W)
   ) u_pick (
      .mask_i  (ready_vec),
      .start_i (pick_start),
      .found_o (pick_found),
      .pid_o   (pick_pid)
   );

   // Event priority: end beats IO beats expiry; a lone expiry never leaves RUN.
   assign run_active = (state_q == ST_RUN) && enable;
   assign expiry     = run_active && instr_retired && (quant_q == QW'(QUANTUM - 1));
   assign ev_end     = run_active && proc_end;
   assign ev_io      = run_active && io_request && !proc_end;
   assign ev_exp_sw  = expiry && !proc_end && !io_request && (|ready_vec);
   assign go_save    = ev_end || ev_io || ev_exp_sw;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (enable && (|ready_vec)) state_d = ST_SELECT;
         ST_RUN:    if (go_save) state_d = ST_SAVE;
         ST_SAVE:   state_d = ST_SELECT;
         ST_SELECT: state_d = pick_found ? ST_SWITCH : ST_IDLE;
         ST_SWITCH: if (ctx_ack) state_d = ST_RUN;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      switch_req   = (state_q == ST_SWITCH);
      switch_cause = cause_q;
      next_pid     = nxt_q;
      restore_pc   = rpc_q;
      current_pid  = cur_q;
      ready_mask   = ready_vec;
      idle         = ~(|ready_vec) & ~(|run_vec);
   end

   always_comb begin
      slot_d  = slot_q;
      pc_d    = pc_q;
      quant_d = quant_q;
      cur_d   = cur_q;
      nxt_d   = nxt_q;
      rpc_d   = rpc_q;
      cause_d = cause_q;

      // Host-side updates apply in every state; create is applied last so it wins.
      if (io_done && (io_done_pid != PID_W'(OS_PID)) &&
          (slot_q[io_done_pid] == SLOT_BLOCKED)) begin
         slot_d[io_done_pid] = SLOT_READY;
      end
      if (proc_create && (proc_create_pid != PID_W'(OS_PID)) &&
          (slot_q[proc_create_pid] != SLOT_RUNNING)) begin
         slot_d[proc_create_pid] = SLOT_READY;
         pc_d[proc_create_pid]   = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable && (|ready_vec)) cause_d = CAUSE_INIT;
         end
         ST_RUN: begin
            if (run_active && instr_retired) begin
               quant_d = expiry ? '0 : quant_q + QW'(1);
            end
            if (ev_end)         cause_d = CAUSE_END;
            else if (ev_io)     cause_d = CAUSE_IO;
            else if (ev_exp_sw) cause_d = CAUSE_QUANTUM;
         end
         ST_SAVE: begin
            pc_d[cur_q] = pc_current;
            case (cause_q)
               CAUSE_QUANTUM: slot_d[cur_q] = SLOT_READY;
               CAUSE_IO:      slot_d[cur_q] = SLOT_BLOCKED;
               default:       slot_d[cur_q] = SLOT_FREE;
            endcase
         end
         ST_SELECT: begin
            if (pick_found) begin
               nxt_d = pick_pid;
               rpc_d = pc_q[pick_pid];
            end else begin
               cur_d = '0;
            end
         end
         ST_SWITCH: begin
            if (ctx_ack) begin
               cur_d          = nxt_q;
               quant_d        = '0;
               slot_d[nxt_q]  = SLOT_RUNNING;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPROC; i++) begin
            slot_q[i] <= SLOT_FREE;
            pc_q[i]   <= '0;
         end
         quant_q <= '0;
         cur_q   <= '0;
         nxt_q   <= '0;
         rpc_q   <= '0;
         cause_q <= CAUSE_QUANTUM;
      end else begin
         slot_q  <= slot_d;
         pc_q    <= pc_d;
         quant_q <= quant_d;
         cur_q   <= cur_d;
         nxt_q   <= nxt_d;
         rpc_q   <= rpc_d;
         cause_q <= cause_d;
      end
   end

endmodule

// File: tb/tb_process_scheduler_rr.sv
// Scenario bench for process_scheduler_rr: expected context switches are queued
// when the triggering stimulus is driven and compared when switch_req rises.
module tb_process_scheduler_rr;

   localparam int NPROC = 8;
   localparam int PID_W = 3;
   localparam int PC_W  = 32;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             instr_retired = 1'b0;
   logic             proc_create = 1'b0;
   logic [PID_W-1:0] proc_create_pid = '0;
   logic             io_request = 1'b0;
   logic             io_done = 1'b0;
   logic [PID_W-1:0] io_done_pid = '0;
   logic             proc_end = 1'b0;
   logic [PC_W-1:0]  pc_current = '0;
   logic             ctx_ack = 1'b0;
   logic             switch_req;
   logic [1:0]       switch_cause;
   logic [PID_W-1:0] next_pid;
   logic [PC_W-1:0]  restore_pc;
   logic [PID_W-1:0] current_pid;
   logic             idle;
   logic [NPROC-1:0] ready_mask;

   process_scheduler_rr #(
      .NPROC(NPROC), .PID_W(PID_W), .QUANTUM(16), .PC_W(PC_W)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .instr_retired(instr_retired),
      .proc_create(proc_create), .proc_create_pid(proc_create_pid),
      .io_request(io_request), .io_done(io_done), .io_done_pid(io_done_pid),
      .proc_end(proc_end), .pc_current(pc_current), .ctx_ack(ctx_ack),
      .switch_req(switch_req), .switch_cause(switch_cause), .next_pid(next_pid),
      .restore_pc(restore_pc), .current_pid(current_pid), .idle(idle),
      .ready_mask(ready_mask)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]       cause;
      logic [PID_W-1:0] pid;
      logic [PC_W-1:0]  pc;
   } sw_t;

   sw_t exp_q[$];
   sw_t expv;
   int  checks = 0;
   int  failures = 0;
   int  lat;
   bit  saw;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic retire(input int k);
      instr_retired = 1'b1;
      repeat (k) tick();
      instr_retired = 1'b0;
   endtask

   task automatic wait_switch(input int bound, output int n);
      n = 0;
      while (!switch_req && n < bound) begin
         tick();
         n++;
      end
      if (!switch_req) n = -1;
   endtask

   task automatic ack_switch();
      ctx_ack = 1'b1;
      tick();
      ctx_ack = 1'b0;
   endtask

   task automatic watch_no_switch(input int k);
      saw = 1'b0;
      repeat (k) begin
         tick();
         if (switch_req) saw = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      checks++;
      if ({switch_req, switch_cause, next_pid, restore_pc} !== '0) begin
         failures++;
         $display("FAIL reset_switch_outs got=%0h exp=0", {switch_req, switch_cause, next_pid, restore_pc});
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({current_pid, ready_mask} !== '0) begin
         failures++;
         $display("FAIL reset_pid_mask got=%0h exp=0", {current_pid, ready_mask});
      end
      checks++;
      if (idle !== 1'b1) begin
         failures++;
         $display("FAIL reset_idle got=%0b exp=1", idle);
      end
   endtask

   task automatic test_initial_dispatch();
      proc_create = 1'b1; proc_create_pid = 3'd1; tick();
      proc_create_pid = 3'd2; tick();
      proc_create = 1'b0;
      checks++;
      if (ready_mask !== 8'h06) begin
         failures++;
         $display("FAIL create_mask got=%0h exp=06", ready_mask);
      end
      exp_q.push_back('{cause: 2'b11, pid: 3'd1, pc: 32'h0});
      enable = 1'b1;
      wait_switch(8, lat);
      expv = exp_q.pop_front();
      checks++;
      if ({switch_req, switch_cause, next_pid, restore_pc} !== {1'b1, expv}) begin
         failures++;
         $display("FAIL init_dispatch got=%0h exp=%0h", {switch_req, switch_cause, next_pid, restore_pc}, {1'b1, expv});
      end
      checks++;
      if (lat != 2) begin
         failures++;
         $display("FAIL init_latency got=%0d exp=2", lat);
      end
      ack_switch();
      checks++;
      if ({switch_req, current_pid, ready_mask} !== {1'b0, 3'd1, 8'h04}) begin
         failures++;
         $display("FAIL init_ack got=%0h exp=%0h", {switch_req, current_pid, ready_mask}, {1'b0, 3'd1, 8'h04});
      end
   endtask

   task automatic test_quantum();
      pc_current = 32'h20;
      exp_q.push_back('{cause: 2'b00, pid: 3'd2, pc: 32'h0});
      retire(16);
      wait_switch(8, lat);
      expv = exp_q.pop_front();
      checks++;
      if ({switch_req, switch_cause, next_pid, restore_pc} !== {1'b1, expv}) begin
         failures++;
         $display("FAIL quantum_switch got=%0h exp=%0h", {switch_req, switch_cause, next_pid, restore_pc}, {1'b1, expv});
      end
      checks++;
      if (lat != 2) begin
         failures++;
         $display("FAIL quantum_latency got=%0d exp=2", lat);
      end
      ack_switch();
      checks++;
      if ({current_pid, ready_mask} !== {3'd2, 8'h02}) begin
         failures++;
         $display("FAIL quantum_ack got=%0h exp=%0h", {current_pid, ready_mask}, {3'd2, 8'h02});
      end
   endtask

   task automatic test_io_block();
      pc_current = 32'h44;
      exp_q.push_back('{cause: 2'b01, pid: 3'd1, pc: 32'h20});
      io_request = 1'b1; tick(); io_request = 1'b0;
      wait_switch(8, lat);
      expv = exp_q.pop_front();
      checks++;
      if ({switch_req, switch_cause, next_pid, restore_pc} !== {1'b1, expv}) begin
         failures++;
         $display("FAIL io_switch got=%0h exp=%0h", {switch_req, switch_cause, next_pid, restore_pc}, {1'b1, expv});
      end
      checks++;
      if (lat != 2) begin
         failures++;
         $display("FAIL io_latency got=%0d exp=2", lat);
      end
      ack_switch();
      checks++;
      if ({current_pid, ready_mask} !== {3'd1, 8'h00}) begin
         failures++;
         $display("FAIL io_ack got=%0h exp=%0h", {current_pid, ready_mask}, {3'd1, 8'h00});
      end
   endtask

   task automatic test_lone_expiry();
      pc_current = 32'h50;
      retire(16);
      watch_no_switch(5);
      checks++;
      if ({saw, current_pid} !== {1'b0, 3'd1}) begin
         failures++;
         $display("FAIL lone_expiry got=%0h exp=%0h", {saw, current_pid}, {1'b0, 3'd1});
      end
      io_done = 1'b1; io_done_pid = 3'd5; tick();
      checks++;
      if (ready_mask !== 8'h00) begin
         failures++;
         $display("FAIL io_done_free_ignored got=%0h exp=00", ready_mask);
      end
      io_done_pid = 3'd2; tick(); io_done = 1'b0;
      checks++;
      if (ready_mask !== 8'h04) begin
         failures++;
         $display("FAIL io_done_ready got=%0h exp=04", ready_mask);
      end
      retire(15);
      watch_no_switch(3);
      checks++;
      if (saw !== 1'b0) begin
         failures++;
         $display("FAIL quantum_restart_early got=%0b exp=0", saw);
      end
      pc_current = 32'h60;
      exp_q.push_back('{cause: 2'b00, pid: 3'd2, pc: 32'h44});
      retire(1);
      wait_switch(8, lat);
      expv = exp_q.pop_front();
      checks++;
      if ({switch_req, switch_cause, next_pid, restore_pc} !== {1'b1, expv}) begin
         failures++;
         $display("FAIL restart_switch got=%0h exp=%0h", {switch_req, switch_cause, next_pid, restore_pc}, {1'b1, expv});
      end
      checks++;
      if (lat != 2) begin
         failures++;
         $display("FAIL restart_latency got=%0d exp=2", lat);
      end
      ack_switch();
   endtask

   task automatic test_end_priority();
      pc_current = 32'h70;
      retire(15);
      exp_q.push_back('{cause: 2'b10, pid: 3'd1, pc: 32'h60});
      proc_end = 1'b1; io_request = 1'b1; instr_retired = 1'b1;
      tick();
      proc_end = 1'b0; io_request = 1'b0; instr_retired = 1'b0;
      wait_switch(8, lat);
      expv = exp_q.pop_front();
      checks++;
      if ({switch_req, switch_cause, next_pid, restore_pc} !== {1'b1, expv}) begin
         failures++;
         $display("FAIL end_switch got=%0h exp=%0h", {switch_req, switch_cause, next_pid, restore_pc}, {1'b1, expv});
      end
      ack_switch();
      io_done = 1'b1; io_done_pid = 3'd2; tick(); io_done = 1'b0;
      checks++;
      if ({current_pid, ready_mask} !== {3'd1, 8'h00}) begin
         failures++;
         $display("FAIL end_freed got=%0h exp=%0h", {current_pid, ready_mask}, {3'd1, 8'h00});
      end
      proc_end = 1'b1; tick(); proc_end = 1'b0;
      watch_no_switch(3);
      checks++;
      if ({saw, idle, current_pid} !== {1'b0, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL last_end_idle got=%0h exp=%0h", {saw, idle, current_pid}, {1'b0, 1'b1, 3'd0});
      end
   endtask

   task automatic test_create_rules();
      proc_create = 1'b1; proc_create_pid = 3'd0; tick(); proc_create = 1'b0;
      checks++;
      if ({ready_mask, idle} !== {8'h00, 1'b1}) begin
         failures++;
         $display("FAIL create_pid0 got=%0h exp=%0h", {ready_mask, idle}, {8'h00, 1'b1});
      end
      exp_q.push_back('{cause: 2'b11, pid: 3'd3, pc: 32'h0});
      proc_create = 1'b1; proc_create_pid = 3'd3;
      io_done = 1'b1; io_done_pid = 3'd4;
      tick();
      proc_create = 1'b0; io_done = 1'b0;
      checks++;
      if (ready_mask !== 8'h08) begin
         failures++;
         $display("FAIL create_and_io_done got=%0h exp=08", ready_mask);
      end
      wait_switch(8, lat);
      expv = exp_q.pop_front();
      checks++;
      if ({switch_req, switch_cause, next_pid, restore_pc} !== {1'b1, expv}) begin
         failures++;
         $display("FAIL redispatch got=%0h exp=%0h", {switch_req, switch_cause, next_pid, restore_pc}, {1'b1, expv});
      end
   endtask

   task automatic test_reset_mid_switch();
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({switch_req, next_pid, current_pid, ready_mask} !== '0) begin
         failures++;
         $display("FAIL reset_mid_switch got=%0h exp=0", {switch_req, next_pid, current_pid, ready_mask});
      end
      checks++;
      if (idle !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_idle got=%0b exp=1", idle);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_initial_dispatch();
      test_quantum();
      test_io_block();
      test_lone_expiry();
      test_end_priority();
      test_create_rules();
      test_reset_mid_switch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
